// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC write-back (FIFO drain) datapath.
package dmac_pkg;

    localparam int unsigned DMAC_MAX_LEN  = 16;
    localparam int unsigned DMAC_ADDR_INC = 4;
    localparam int unsigned DMAC_LEN_W    = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } dmac_state_e;

endpackage

// File: rtl/dmac_addr_cnt.sv
// Destination address register, remaining-word down-counter and transferred-word up-counter.
module dmac_addr_cnt
    import dmac_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ADDR_INC = DMAC_ADDR_INC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DMAC_LEN_W-1:0] load_len,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic [DMAC_LEN_W-1:0] xfer_cnt,
    output logic                  last
);

    logic [DMAC_LEN_W-1:0] remaining;

    // Current word is the final one of the transfer.
    assign last = (remaining == DMAC_LEN_W'(1));

    // Load on an accepted start, advance once per granted bus write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            xfer_cnt  <= '0;
        end else if (load) begin
            cur_addr  <= load_addr;
            remaining <= load_len;
            xfer_cnt  <= '0;
        end else if (step) begin
            cur_addr  <= cur_addr + ADDR_W'(ADDR_INC);
            remaining <= remaining - DMAC_LEN_W'(1);
            xfer_cnt  <= xfer_cnt + DMAC_LEN_W'(1);
        end
    end

endmodule

// File: rtl/dmac_fifo_drain.sv
// Write-back sequencer: reads words from the FIFO one at a time and writes them
// to consecutive bus addresses through a req/grant master port.
module dmac_fifo_drain
    import dmac_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LEN  = DMAC_MAX_LEN,
    parameter int unsigned ADDR_INC = DMAC_ADDR_INC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [DMAC_LEN_W-1:0] length,
    output logic                  fifo_rd_en,
    input  logic [DATA_W-1:0]     fifo_dout,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    output logic                  m_req,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_grant,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DMAC_LEN_W-1:0] xfer_cnt
);

    dmac_state_e           state;
    dmac_state_e           state_d;
    logic [DATA_W-1:0]     data_reg;
    logic                  abort_pend;
    logic                  len_zero;
    logic                  len_over;
    logic                  cnt_load;
    logic                  cnt_step;
    logic                  cnt_last;
    logic                  stop_req;

    assign len_zero = (length == '0);
    assign len_over = (length > DMAC_LEN_W'(MAX_LEN));
    assign cnt_load = (state == IDLE) && start && !len_over;
    assign cnt_step = (state == WR) && m_grant;
    assign stop_req = abort || abort_pend;

    assign m_wdata = data_reg;

    // Address and word counters.
    dmac_addr_cnt #(
        .ADDR_W   (ADDR_W),
        .ADDR_INC (ADDR_INC)
    ) u_addr_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .step      (cnt_step),
        .load_addr (dst_addr),
        .load_len  (length),
        .cur_addr  (m_addr),
        .xfer_cnt  (xfer_cnt),
        .last      (cnt_last)
    );

    // Next-state decode; abort takes priority over FIFO responses, and in WR
    // it is only honoured on the grant edge so the granted word completes.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_zero)      state_d = DONE;
                    else if (len_over) state_d = ERR;
                    else               state_d = RD;
                end
            end
            RD: begin
                state_d = abort ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (abort)            state_d = IDLE;
                else if (fifo_rd_ack) state_d = WR;
                else if (fifo_rd_err) state_d = ERR;
            end
            WR: begin
                if (m_grant) begin
                    if (stop_req)      state_d = IDLE;
                    else if (cnt_last) state_d = DONE;
                    else               state_d = RD;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            m_req      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            data_reg   <= '0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_d;
            fifo_rd_en <= (state_d == RD);
            m_req      <= (state_d == WR);
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);

            if (cnt_load)              err <= 1'b0;
            else if (state_d == ERR)   err <= 1'b1;

            if ((state == RD_WAIT) && fifo_rd_ack && !abort)
                data_reg <= fifo_dout;

            abort_pend <= (state == WR) && m_grant ? 1'b0 :
                          (state == WR) ? (abort_pend || abort) : 1'b0;
        end
    end

endmodule

// File: tb/tb_dmac_fifo_drain.sv
// Directed bench for dmac_fifo_drain with a FIFO responder and a stallable bus slave.
module tb_dmac_fifo_drain;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] dst_addr;
    logic [4:0]  length;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_grant;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  xfer_cnt;

    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] fifo_q[$];
    logic [63:0] wr_log[$];
    int          stall = 0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          b2b_cnt = 0;
    logic        prev_rd = 1'b0;

    dmac_fifo_drain u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .dst_addr    (dst_addr),
        .length      (length),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_grant     (m_grant),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Bus slave grants after 'stall' request cycles.
    assign m_grant = m_req && (wait_cnt >= stall);

    always @(posedge clk) begin
        if (m_req && !m_grant) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
        if (m_req && m_grant) wr_log.push_back({m_addr, m_wdata});
    end

    // FIFO read side: answers one cycle after a read request.
    initial begin
        fifo_dout   = '0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
    end

    always @(posedge clk) begin
        fifo_rd_ack <= 1'b0;
        fifo_rd_err <= 1'b0;
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (fifo_q.size() > 0) begin
                fifo_dout   <= fifo_q.pop_front();
                fifo_rd_ack <= 1'b1;
            end else begin
                fifo_rd_err <= 1'b1;
            end
        end
        if (fifo_rd_en && prev_rd) b2b_cnt = b2b_cnt + 1;
        prev_rd = fifo_rd_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a start pulse; returns just after the sampling edge.
    task automatic kick(input logic [31:0] a, input logic [4:0] l);
        @(negedge clk);
        start    = 1'b1;
        dst_addr = a;
        length   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run until idle. lat = edges after the start edge at which done is first seen.
    task automatic run_idle(input string tag, input int budget,
                            output int lat, output int done_cnt);
        bit finished = 0;
        lat = -1;
        done_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                if (lat < 0) lat = i;
                done_cnt++;
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, " idle-timeout"}, 64'(finished), 64'd1);
    endtask

    int lat;
    int dcnt;
    int rd0;
    int n_low;
    logic [63:0] ent;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dst_addr = '0;
        length   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst rd_en",  64'(fifo_rd_en), 64'd0);
        check("rst m_req",  64'(m_req),      64'd0);
        check("rst m_addr", 64'(m_addr),     64'd0);
        check("rst wdata",  64'(m_wdata),    64'd0);
        check("rst busy",   64'(busy),       64'd0);
        check("rst done",   64'(done),       64'd0);
        check("rst err",    64'(err),        64'd0);
        check("rst xfer",   64'(xfer_cnt),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three words, grant always ready.
        fifo_q = '{32'hA, 32'hB, 32'hC};
        wr_log.delete();
        stall = 0;
        kick(32'h100, 5'd3);
        run_idle("t1", 40, lat, dcnt);
        check("t1 latency", 64'(lat), 64'd9);
        check("t1 done width", 64'(dcnt), 64'd1);
        check("t1 nwr", 64'(wr_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            ent = (i < wr_log.size()) ? wr_log[i] : 64'hX;
            check($sformatf("t1 wr%0d", i), ent, {32'h100 + 32'(4 * i), 32'hA + 32'(i)});
        end
        check("t1 xfer", 64'(xfer_cnt), 64'd3);
        check("t1 err", 64'(err), 64'd0);

        // FIFO runs dry on the second word.
        fifo_q = '{32'h11};
        wr_log.delete();
        kick(32'h200, 5'd2);
        run_idle("t2", 40, lat, dcnt);
        check("t2 no done", 64'(dcnt), 64'd0);
        check("t2 err", 64'(err), 64'd1);
        check("t2 xfer", 64'(xfer_cnt), 64'd1);
        check("t2 nwr", 64'(wr_log.size()), 64'd1);

        // Full 16-word transfer, two stall cycles per write.
        fifo_q.delete();
        for (int i = 0; i < 16; i++) fifo_q.push_back(32'h1000 + 32'(i));
        wr_log.delete();
        stall = 2;
        kick(32'h4000, 5'd16);
        run_idle("t3", 200, lat, dcnt);
        check("t3 latency", 64'(lat), 64'd80);
        check("t3 nwr", 64'(wr_log.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            ent = (i < wr_log.size()) ? wr_log[i] : 64'hX;
            check($sformatf("t3 wr%0d", i), ent, {32'h4000 + 32'(4 * i), 32'h1000 + 32'(i)});
        end
        check("t3 fifo empty", 64'(fifo_q.size()), 64'd0);
        check("t3 xfer", 64'(xfer_cnt), 64'd16);
        check("t3 err cleared", 64'(err), 64'd0);

        // Address wrap.
        fifo_q = '{32'h21, 32'h22};
        wr_log.delete();
        stall = 0;
        kick(32'hFFFF_FFFC, 5'd2);
        run_idle("t4", 40, lat, dcnt);
        check("t4 latency", 64'(lat), 64'd6);
        check("t4 nwr", 64'(wr_log.size()), 64'd2);
        ent = (wr_log.size() > 0) ? wr_log[0] : 64'hX;
        check("t4 wr0", ent, {32'hFFFF_FFFC, 32'h21});
        ent = (wr_log.size() > 1) ? wr_log[1] : 64'hX;
        check("t4 wr1", ent, {32'h0000_0000, 32'h22});

        // Abort while waiting for grant.
        fifo_q = '{32'hA1, 32'hA2, 32'hA3};
        wr_log.delete();
        stall = 3;
        kick(32'h300, 5'd3);
        for (int i = 0; i < 10 && !m_req; i++) begin
            @(posedge clk);
            #1;
        end
        check("t5 m_req seen", 64'(m_req), 64'd1);
        abort = 1'b1;
        n_low = 0;
        for (int i = 0; i < 10 && !m_grant; i++) begin
            check("t5 m_req held", 64'(m_req), 64'd1);
            check("t5 addr held", 64'(m_addr), 64'h300);
            check("t5 data held", 64'(m_wdata), 64'hA1);
            n_low++;
            @(posedge clk);
            #1;
        end
        check("t5 grant-low cycles", 64'(n_low), 64'd3);
        @(posedge clk);
        #1;
        abort = 1'b0;
        run_idle("t5", 20, lat, dcnt);
        check("t5 no done", 64'(dcnt), 64'd0);
        check("t5 nwr", 64'(wr_log.size()), 64'd1);
        ent = (wr_log.size() > 0) ? wr_log[0] : 64'hX;
        check("t5 wr0", ent, {32'h300, 32'hA1});
        check("t5 xfer", 64'(xfer_cnt), 64'd1);
        check("t5 err", 64'(err), 64'd0);
        fifo_q = '{32'h55};
        wr_log.delete();
        stall = 0;
        kick(32'h500, 5'd1);
        run_idle("t5b", 20, lat, dcnt);
        check("t5b latency", 64'(lat), 64'd3);
        ent = (wr_log.size() > 0) ? wr_log[0] : 64'hX;
        check("t5b wr0", ent, {32'h500, 32'h55});

        // Zero length: done occupies the cycle right after the sampling edge.
        rd0 = rd_cnt;
        wr_log.delete();
        kick(32'h600, 5'd0);
        check("t6 done", 64'(done), 64'd1);
        run_idle("t6", 10, lat, dcnt);
        check("t6 done width", 64'(dcnt), 64'd1);
        check("t6 no rd", 64'(rd_cnt - rd0), 64'd0);
        check("t6 xfer", 64'(xfer_cnt), 64'd0);

        // Over-length request.
        kick(32'h700, 5'd17);
        run_idle("t7", 10, lat, dcnt);
        check("t7 err", 64'(err), 64'd1);
        check("t7 no done", 64'(dcnt), 64'd0);
        check("t7 no rd", 64'(rd_cnt - rd0), 64'd0);
        check("t7 no wr", 64'(wr_log.size()), 64'd0);

        // Reset in the middle of a transfer.
        fifo_q = '{32'h71, 32'h72, 32'h73};
        kick(32'h800, 5'd3);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t8 pre-rst xfer", 64'(xfer_cnt), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t8 busy", 64'(busy), 64'd0);
        check("t8 xfer", 64'(xfer_cnt), 64'd0);
        check("t8 m_req", 64'(m_req), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t8 idle", 64'(busy), 64'd0);

        check("no back-to-back reads", 64'(b2b_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
